// File: rtl/payload_tone_sched_if.sv
// Frame request, upstream bit stream and PTMU-facing bit stream bundle.
// Ports: start/frame_bits request; s_dat/s_vld/s_rdy upstream handshake; di/di_vld to PTMU;
//        busy/sym_cnt/frame_done/err status. "slave" is the scheduler side, "master" the driver side.
interface payload_tone_sched_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] frame_bits;
    logic             s_dat;
    logic             s_vld;
    logic             s_rdy;
    logic             di;
    logic             di_vld;
    logic             busy;
    logic [7:0]       sym_cnt;
    logic             frame_done;
    logic             err;

    modport master (
        output start, frame_bits, s_dat, s_vld,
        input  s_rdy, di, di_vld, busy, sym_cnt, frame_done, err
    );

    modport slave (
        input  start, frame_bits, s_dat, s_vld,
        output s_rdy, di, di_vld, busy, sym_cnt, frame_done, err
    );
endinterface

// File: rtl/payload_tone_sched.sv
// Pulls a frame of coded bits, emits them to the PTMU in gap-free sub-carrier groups, zero-pads to a whole symbol.
// Ports: clk, rst_n (async, active low), bus (slave modport). Latency: first di_vld one cycle after a group fills.
// Backpressure: upstream stalls hold the block in FILL; s_rdy is low while a group is emitted or the tail is padded.
module payload_tone_sched #(
    parameter int SC_NUM      = 96,
    parameter int BITS_PER_SC = 4,
    parameter int LEN_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    payload_tone_sched_if.slave  bus
);
    localparam int BW   = (BITS_PER_SC > 1) ? $clog2(BITS_PER_SC) : 1;
    localparam int SC_W = (SC_NUM > 1) ? $clog2(SC_NUM) : 1;
    localparam logic [BW-1:0]   BIT_LAST = BW'(BITS_PER_SC - 1);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SC_NUM - 1);

    typedef enum logic [2:0] {IDLE, FILL, EMIT, PAD, DONE} state_t;

    state_t                 state, state_nxt;
    logic [BITS_PER_SC-1:0] grp, grp_nxt;
    logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [SC_W-1:0]        sc_cnt, sc_cnt_nxt;
    logic [7:0]             sym_cnt, sym_cnt_nxt;
    logic [LEN_W-1:0]       remaining, remaining_nxt;
    logic                   di_q, di_nxt;
    logic                   di_vld_q, s_rdy_q, busy_q, frame_done_q, err_q;
    logic                   sc_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grp          <= '0;
            bit_cnt      <= '0;
            sc_cnt       <= '0;
            sym_cnt      <= '0;
            remaining    <= '0;
            di_q         <= 1'b0;
            di_vld_q     <= 1'b0;
            s_rdy_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            grp          <= grp_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sc_cnt       <= sc_cnt_nxt;
            sym_cnt      <= sym_cnt_nxt;
            remaining    <= remaining_nxt;
            di_q         <= di_nxt;
            // Output flags are decoded from the next state so they line up with it.
            di_vld_q     <= (state_nxt == EMIT) || (state_nxt == PAD);
            s_rdy_q      <= (state_nxt == FILL);
            busy_q       <= (state_nxt == FILL) || (state_nxt == EMIT) || (state_nxt == PAD);
            frame_done_q <= (state_nxt == DONE) ||
                            ((state == IDLE) && bus.start && (bus.frame_bits == '0));
            err_q        <= bus.start && busy_q;
        end
    end

    always_comb begin
        state_nxt     = state;
        grp_nxt       = grp;
        bit_cnt_nxt   = bit_cnt;
        sc_cnt_nxt    = sc_cnt;
        sym_cnt_nxt   = sym_cnt;
        remaining_nxt = remaining;
        di_nxt        = 1'b0;
        sc_wrap       = (sc_cnt == SC_LAST);

        case (state)
            IDLE: begin
                if (bus.start && (bus.frame_bits != '0)) begin
                    remaining_nxt = bus.frame_bits;
                    bit_cnt_nxt   = '0;
                    sc_cnt_nxt    = '0;
                    sym_cnt_nxt   = '0;
                    grp_nxt       = '0;
                    state_nxt     = FILL;
                end
            end
            FILL: begin
                if (bus.s_vld && s_rdy_q) begin
                    // The group buffer is all-zero on entry, so a short tail group is zero-filled for free.
                    grp_nxt[bit_cnt] = bus.s_dat;
                    remaining_nxt    = remaining - LEN_W'(1);
                    if ((bit_cnt == BIT_LAST) || (remaining == LEN_W'(1))) begin
                        // Present bit 0 now and keep the rest shifted down for the following cycles.
                        di_nxt      = grp_nxt[0];
                        grp_nxt     = grp_nxt >> 1;
                        bit_cnt_nxt = '0;
                        state_nxt   = EMIT;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            EMIT: begin
                if (bit_cnt != BIT_LAST) begin
                    di_nxt      = grp[0];
                    grp_nxt     = grp >> 1;
                    bit_cnt_nxt = bit_cnt + BW'(1);
                end else begin
                    grp_nxt     = '0;
                    bit_cnt_nxt = '0;
                    sc_cnt_nxt  = sc_wrap ? '0 : sc_cnt + SC_W'(1);
                    if (sc_wrap) begin
                        sym_cnt_nxt = sym_cnt + 8'd1;
                    end
                    if (remaining != '0) begin
                        state_nxt = FILL;
                    end else if (sc_wrap) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (bit_cnt != BIT_LAST) begin
                    bit_cnt_nxt = bit_cnt + BW'(1);
                end else begin
                    bit_cnt_nxt = '0;
                    if (sc_wrap) begin
                        sc_cnt_nxt  = '0;
                        sym_cnt_nxt = sym_cnt + 8'd1;
                        state_nxt   = DONE;
                    end else begin
                        sc_cnt_nxt = sc_cnt + SC_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.s_rdy      = s_rdy_q;
    assign bus.di         = di_q;
    assign bus.di_vld     = di_vld_q;
    assign bus.busy       = busy_q;
    assign bus.sym_cnt    = sym_cnt;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_payload_tone_sched.sv
// Bench for payload_tone_sched: random frames and upstream stalls checked against a padded-stream reference.
// Ports: none; drives the interface master side and generates clk.
// Expected output = input bits followed by zeros up to a whole number of 384-bit symbols.
module tb_payload_tone_sched;
    localparam int SC_NUM      = 96;
    localparam int BITS_PER_SC = 4;
    localparam int SYM_BITS    = SC_NUM * BITS_PER_SC;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    payload_tone_sched_if #(.LEN_W(16)) bus ();

    payload_tone_sched #(
        .SC_NUM(SC_NUM),
        .BITS_PER_SC(BITS_PER_SC),
        .LEN_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vld_mode: 0 = always valid, 1 = toggle every cycle, 2 = random.
    // inj_cyc >= 0 pulses a second start (frame_bits=50) at that cycle of the frame.
    task automatic run_frame(input int n, input int vld_mode, input int inj_cyc, input string name);
        bit src[$];
        bit got[$];
        int idx, runlen, bad_runs, rdy_viol, done_cnt, err_cnt, cyc, exp_total, seq_bad;
        int sym_seen;
        bit done_seen;
        bit tog;
        idx = 0; runlen = 0; bad_runs = 0; rdy_viol = 0; done_cnt = 0; err_cnt = 0;
        cyc = 0; seq_bad = 0; sym_seen = -1; done_seen = 0; tog = 1'b1;
        for (int i = 0; i < n; i++) src.push_back(1'($urandom_range(0, 1)));
        exp_total = ((n + SYM_BITS - 1) / SYM_BITS) * SYM_BITS;

        @(negedge clk);
        bus.start = 1'b1;
        bus.frame_bits = 16'(n);
        bus.s_vld = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;

        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy);
        end

        while (cyc < 6000 && !done_seen) begin
            if (bus.di_vld === 1'b1) begin
                got.push_back(bus.di);
                runlen++;
            end else begin
                if (runlen % BITS_PER_SC != 0) bad_runs++;
                runlen = 0;
            end
            if (bus.di_vld === 1'b1 && bus.s_rdy === 1'b1) rdy_viol++;
            if (bus.err === 1'b1) err_cnt++;
            if (bus.frame_done === 1'b1) begin
                done_seen = 1'b1;
                done_cnt++;
                sym_seen = int'(bus.sym_cnt);
            end
            bus.start = (cyc == inj_cyc);
            bus.frame_bits = (cyc == inj_cyc) ? 16'd50 : 16'(n);
            case (vld_mode)
                0: bus.s_vld = (idx < n);
                1: bus.s_vld = (idx < n) && tog;
                default: bus.s_vld = (idx < n) && ($urandom_range(0, 2) != 0);
            endcase
            tog = ~tog;
            bus.s_dat = (idx < n) ? src[idx] : 1'b0;
            if (bus.s_vld && bus.s_rdy === 1'b1) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.s_vld = 1'b0;

        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== ((i < n) ? src[i] : 1'b0)) seq_bad++;
        end

        compared++;
        if (!done_seen) begin
            mismatched++;
            $display("FAIL %s frame_done_timeout: got none within %0d cycles want 1", name, cyc);
        end
        compared++;
        if (got.size() != exp_total) begin
            mismatched++;
            $display("FAIL %s di_vld_count: got %0d want %0d", name, got.size(), exp_total);
        end
        compared++;
        if (seq_bad != 0) begin
            mismatched++;
            $display("FAIL %s di_sequence: got %0d wrong bits want 0", name, seq_bad);
        end
        compared++;
        if (idx != n) begin
            mismatched++;
            $display("FAIL %s bits_consumed: got %0d want %0d", name, idx, n);
        end
        compared++;
        if (bad_runs != 0) begin
            mismatched++;
            $display("FAIL %s intra_group_gap: got %0d broken runs want 0", name, bad_runs);
        end
        compared++;
        if (rdy_viol != 0) begin
            mismatched++;
            $display("FAIL %s s_rdy_while_emitting: got %0d cycles want 0", name, rdy_viol);
        end
        compared++;
        if (sym_seen != (exp_total / SYM_BITS) % 256) begin
            mismatched++;
            $display("FAIL %s sym_cnt: got %0d want %0d", name, sym_seen, (exp_total / SYM_BITS) % 256);
        end
        compared++;
        if (err_cnt != ((inj_cyc >= 0) ? 1 : 0)) begin
            mismatched++;
            $display("FAIL %s err_pulses: got %0d want %0d", name, err_cnt, (inj_cyc >= 0) ? 1 : 0);
        end
        compared++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s after_done: got frame_done=%b busy=%b want 0 0", name, bus.frame_done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.frame_bits = '0; bus.s_dat = 1'b0; bus.s_vld = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.di, bus.di_vld, bus.s_rdy, bus.busy, bus.sym_cnt, bus.frame_done, bus.err} !== 14'b0) begin
            mismatched++;
            $display("FAIL reset_state: got di=%b di_vld=%b s_rdy=%b busy=%b sym=%0d done=%b err=%b want all 0",
                     bus.di, bus.di_vld, bus.s_rdy, bus.busy, bus.sym_cnt, bus.frame_done, bus.err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        bus.start = 1'b1;
        bus.frame_bits = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        compared++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.di_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_len_first: got done=%b busy=%b di_vld=%b want 1 0 0",
                     bus.frame_done, bus.busy, bus.di_vld);
        end
        @(negedge clk);
        compared++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.di_vld !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_len_second: got done=%b busy=%b di_vld=%b want 0 0 0",
                     bus.frame_done, bus.busy, bus.di_vld);
        end
    endtask

    task automatic test_reset_mid_emit();
        int seen;
        int cyc;
        seen = 0;
        cyc = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.frame_bits = 16'd384;
        @(negedge clk);
        bus.start = 1'b0;
        while (seen < 2 && cyc < 50) begin
            if (bus.di_vld === 1'b1) seen++;
            if (seen < 2) begin
                bus.s_vld = 1'b1;
                bus.s_dat = 1'($urandom_range(0, 1));
                @(negedge clk);
                cyc++;
            end
        end
        compared++;
        if (seen < 2) begin
            mismatched++;
            $display("FAIL reset_mid_emit_reach: got %0d di_vld cycles want 2", seen);
        end
        bus.s_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.di_vld !== 1'b0 || bus.busy !== 1'b0 || bus.s_rdy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async: got di_vld=%b busy=%b s_rdy=%b want 0 0 0",
                     bus.di_vld, bus.busy, bus.s_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(384, 0, -1, "after_reset");
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        test_reset();
        run_frame(384, 0, -1, "full_symbol");
        run_frame(10, 0, -1, "short_pad");
        run_frame(8, 1, -1, "toggle_vld");
        run_frame(200, 0, 40, "start_while_busy");
        test_zero_len();
        test_reset_mid_emit();
        run_frame(385, 2, -1, "random_385");
        for (int k = 0; k < 3; k++) begin
            run_frame(int'($urandom_range(1, 900)), 2, -1, "random_len");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
